// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    // Write-port source tags reported on rf_src
    localparam logic SRC_PIPE = 1'b0;
    localparam logic SRC_LU   = 1'b1;

    // One buffered long-latency result; valid drops when a younger
    // pipeline write to the same destination supersedes it.
    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] dest;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

    // One-hot register mask for a destination index
    function automatic logic [31:0] dest_onehot(input logic [RF_ADDR_W-1:0] dest);
        return 32'd1 << dest;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of pipeline, long-latency unit and register-file write-port signals.
interface wb_port_arbiter_if;
    import wb_arb_pkg::*;

    logic                 pipe_we;
    logic [RF_ADDR_W-1:0] pipe_dest;
    logic [RF_DATA_W-1:0] pipe_wdata;
    logic                 lu_valid;
    logic                 lu_ready;
    logic [RF_ADDR_W-1:0] lu_dest;
    logic [RF_DATA_W-1:0] lu_wdata;
    logic                 flush;
    logic                 rf_we;
    logic [RF_ADDR_W-1:0] rf_waddr;
    logic [RF_DATA_W-1:0] rf_wdata;
    logic                 rf_src;
    logic [31:0]          pend_mask;
    logic                 starve_stall;

    // Arbiter side
    modport slave (
        input  pipe_we, pipe_dest, pipe_wdata,
        input  lu_valid, lu_dest, lu_wdata, flush,
        output lu_ready, rf_we, rf_waddr, rf_wdata, rf_src,
        output pend_mask, starve_stall
    );

    // Pipeline / long-latency unit / register file side
    modport master (
        output pipe_we, pipe_dest, pipe_wdata,
        output lu_valid, lu_dest, lu_wdata, flush,
        input  lu_ready, rf_we, rf_waddr, rf_wdata, rf_src,
        input  pend_mask, starve_stall
    );

endinterface

// File: rtl/wb_arb_fifo.sv
// Circular buffer of long-latency results with per-entry invalidate-by-dest
// and a pending-destination mask for decode interlock.
module wb_arb_fifo
    import wb_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  logic [RF_ADDR_W-1:0] push_dest,
    input  logic [RF_DATA_W-1:0] push_data,
    input  logic                 pop,
    input  logic                 flush,
    input  logic                 inv_en,
    input  logic [RF_ADDR_W-1:0] inv_dest,
    output wb_entry_t            head,
    output logic [CNT_W-1:0]     count,
    output logic [31:0]          pend_mask
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // valid_reg is cleared for unoccupied slots, so it alone marks live entries
    logic [DEPTH-1:0]     valid_reg;
    logic [DEPTH-1:0]     valid_next;
    logic [RF_ADDR_W-1:0] dest_reg [DEPTH];
    logic [RF_DATA_W-1:0] data_reg [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;
    logic [DEPTH-1:0]     inv_hit;
    logic [31:0]          ent_mask [DEPTH];
    logic [31:0]          mask_or;
    logic                 push_ok;
    logic                 pop_ok;

    assign push_ok = push && (count_reg != FULL_CNT);
    assign pop_ok  = pop && (count_reg != '0);

    // Per-entry WAW match and pending-mask contribution
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign inv_hit[gi]  = inv_en && valid_reg[gi] && (inv_dest != '0)
                                  && (dest_reg[gi] == inv_dest);
            assign ent_mask[gi] = valid_reg[gi] ? dest_onehot(dest_reg[gi]) : 32'd0;
        end
    endgenerate

    // Next valid bits and occupancy
    always_comb begin
        valid_next = valid_reg & ~inv_hit;
        if (pop_ok) begin
            valid_next[rd_ptr_reg] = 1'b0;
        end
        if (push_ok) begin
            valid_next[wr_ptr_reg] = 1'b1;
        end
        count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Control state: pointers, count, valid bits
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            valid_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Payload storage, written only on enqueue
    always_ff @(posedge clk) begin
        if (push_ok && rstn && !flush) begin
            dest_reg[wr_ptr_reg] <= push_dest;
            data_reg[wr_ptr_reg] <= push_data;
        end
    end

    // OR of live destinations; r0 is never reported
    always_comb begin
        mask_or = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mask_or = mask_or | ent_mask[i];
        end
    end

    assign pend_mask  = mask_or & ~32'd1;
    assign count      = count_reg;
    assign head.valid = valid_reg[rd_ptr_reg];
    assign head.dest  = dest_reg[rd_ptr_reg];
    assign head.data  = data_reg[rd_ptr_reg];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between Writeback (always wins) and a
// buffered long-latency result stream, with a starvation stall request.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rstn,
    wb_port_arbiter_if.slave  bus
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] LIM      = WAIT_W'(STARVE_LIM);

    wb_entry_t          head;
    logic [CNT_W-1:0]   count;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [WAIT_W-1:0]  wait_reg;
    logic [WAIT_W-1:0]  wait_next;
    logic               starve_reg;
    logic               starve_next;

    assign fifo_empty   = (count == '0);
    assign bus.lu_ready = (count != FULL_CNT);
    // Results to r0 are accepted but simply dropped
    assign push = bus.lu_valid && bus.lu_ready && !bus.flush && (bus.lu_dest != '0);
    // Head drains only into cycles the pipeline leaves idle, never during flush
    assign pop  = !bus.pipe_we && !fifo_empty && !bus.flush;

    wb_arb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_dest (bus.lu_dest),
        .push_data (bus.lu_wdata),
        .pop       (pop),
        .flush     (bus.flush),
        .inv_en    (bus.pipe_we),
        .inv_dest  (bus.pipe_dest),
        .head      (head),
        .count     (count),
        .pend_mask (bus.pend_mask)
    );

    // Write-port mux: pipeline first, then FIFO head (superseded heads write nothing)
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = head.dest;
        bus.rf_wdata = head.data;
        bus.rf_src   = SRC_PIPE;
        if (bus.pipe_we) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.pipe_dest;
            bus.rf_wdata = bus.pipe_wdata;
        end else if (pop) begin
            bus.rf_we  = head.valid;
            bus.rf_src = SRC_LU;
        end
    end

    // Head wait counter and stall request next-state
    always_comb begin
        wait_next   = wait_reg;
        starve_next = starve_reg;
        if (bus.flush || fifo_empty || pop) begin
            wait_next = '0;
        end else if (wait_reg != LIM) begin
            wait_next = wait_reg + WAIT_W'(1);
        end
        if (bus.flush || pop) begin
            starve_next = 1'b0;
        end else if (wait_reg == LIM) begin
            starve_next = 1'b1;
        end
    end

    // Starvation state registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_reg   <= '0;
            starve_reg <= 1'b0;
        end else begin
            wait_reg   <= wait_next;
            starve_reg <= starve_next;
        end
    end

    assign bus.starve_stall = starve_reg;

endmodule
